// File: rtl/gpio1_clkgen_if.sv
// gpio1_clkgen_if: Avalon-MM slave bus bundle for the GPIO1 clock generator.
// Signals: address[1:0], chipselect, write_n, writedata[15:0] toward the
// slave; readdata[15:0] back to the master.
interface gpio1_clkgen_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [15:0] writedata;
    logic [15:0] readdata;

    modport master (
        output address, chipselect, write_n, writedata,
        input  readdata
    );

    modport slave (
        input  address, chipselect, write_n, writedata,
        output readdata
    );
endinterface

// File: rtl/gpio1_clkgen.sv
// gpio1_clkgen: programmable clock / burst generator for GPIO1.
// Ports: clk, reset (sync, active-high), ctrl_in[1:0] {trigger, run},
// bus (Avalon-MM slave: DIV, BURST, STATUS, REMAIN),
// clk_out[1:0] {rise strobe, divided clock}.
module gpio1_clkgen (
    input  logic          clk,
    input  logic          reset,
    input  logic [1:0]    ctrl_in,
    gpio1_clkgen_if.slave bus,
    output logic [1:0]    clk_out
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_BURST = 2'd2;

    logic [1:0]  state;
    logic [15:0] div;
    logic [15:0] burst;
    logic [15:0] remain;
    logic [15:0] cnt;
    logic        trig_q;
    logic        phase;
    logic        rise;

    logic trig;
    logic wr;
    logic busy;
    logic in_burst;
    logic tick;

    assign trig     = ctrl_in[1] & ~trig_q;
    assign wr       = bus.chipselect & ~bus.write_n;
    assign busy     = (state != ST_IDLE);
    assign in_burst = (state == ST_BURST);
    assign tick     = (cnt == 16'd0);
    assign clk_out  = {rise, phase};

    always_comb begin
        bus.readdata = 16'd0;
        unique case (bus.address)
            2'd0:    bus.readdata = div;
            2'd1:    bus.readdata = burst;
            2'd2:    bus.readdata = {14'b0, in_burst, busy};
            default: bus.readdata = remain;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            div    <= 16'd0;
            burst  <= 16'd0;
            remain <= 16'd0;
            cnt    <= 16'd0;
            trig_q <= 1'b0;
            phase  <= 1'b0;
            rise   <= 1'b0;
        end else begin
            trig_q <= ctrl_in[1];
            rise   <= 1'b0;
            if (wr && bus.address == 2'd0)
                div <= bus.writedata;
            if (wr && bus.address == 2'd1)
                burst <= bus.writedata;

            unique case (state)
                ST_IDLE: begin
                    phase  <= 1'b0;
                    cnt    <= div;
                    remain <= 16'd0;
                    if (ctrl_in[0]) begin
                        state <= ST_RUN;
                    end else if (trig && burst != 16'd0) begin
                        state  <= ST_BURST;
                        remain <= burst;
                    end
                end
                ST_RUN: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        cnt <= div;
                        // Stopping only happens at the end of a low
                        // phase so the last high phase is never cut.
                        if (phase) begin
                            phase <= 1'b0;
                        end else if (!ctrl_in[0]) begin
                            state <= ST_IDLE;
                        end else begin
                            phase <= 1'b1;
                            rise  <= 1'b1;
                        end
                    end
                end
                ST_BURST: begin
                    if (!tick) begin
                        cnt <= cnt - 16'd1;
                    end else begin
                        cnt <= div;
                        if (phase) begin
                            phase  <= 1'b0;
                            remain <= remain - 16'd1;
                            if (remain == 16'd1)
                                state <= ST_IDLE;
                        end else begin
                            phase <= 1'b1;
                            rise  <= 1'b1;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end
endmodule
